// File: rtl/kyber_rng_pkg.sv
// Shared constants and state type for the randomness consumer path.
// Lane geometry of the packed PRNG word and the dispenser FSM state encoding.
package kyber_rng_pkg;
    localparam int COEFF_SZ = 16;
    localparam int LANES    = 6;
    localparam int WORD_W   = COEFF_SZ * LANES;
    localparam int LANE_W   = $clog2(LANES);

    typedef enum logic {INIT = 1'b0, RUN = 1'b1} state_t;
endpackage

// File: rtl/rng_word_fifo.sv
// DEPTH x WORD_W register FIFO holding packed random words.
// Pointers and level are reset; the word storage itself is not.
module rng_word_fifo
    import kyber_rng_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     clear,
    input  logic [WORD_W-1:0]        wr_word,
    output logic [WORD_W-1:0]        head,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;

    logic [WORD_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;

    // DEPTH is a power of two, so pointers wrap naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)
                rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   level <= level + LVL_W'(1);
                2'b01:   level <= level - LVL_W'(1);
                default: level <= level;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push && !clear)
            mem[wr_ptr] <= wr_word;
    end

    assign head = mem[rd_ptr];
endmodule

// File: rtl/rng_mask_dispenser.sv
// Buffers packed PRNG words and hands out one single-use COEFF_SZ-bit mask per transfer.
// Optional repetition health test enabled with macro RNG_HEALTH_EN.
module rng_mask_dispenser
    import kyber_rng_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int PREFILL = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [WORD_W-1:0]       rnd_word,
    input  logic                    rnd_valid,
    output logic                    rnd_ready,
    output logic [COEFF_SZ-1:0]     mask,
    output logic                    mask_valid,
    input  logic                    mask_ready,
    input  logic                    flush,
    output logic [$clog2(DEPTH):0]  level,
    output logic [15:0]             starve_cnt,
    output logic                    health_err
);
    localparam int LVL_W = $clog2(DEPTH) + 1;

    state_t              state;
    logic [LANE_W-1:0]   lane_idx;
    logic [WORD_W-1:0]   head;
    logic                push_acc;
    logic                store;
    logic                pop;
    logic                last_lane;
    logic                dup;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // Ready depends only on fullness, never on a same-cycle pop.
    assign rnd_ready  = rst_n && (level != LVL_W'(DEPTH));
    assign push_acc   = rnd_valid && rnd_ready;
    assign mask_valid = (state == RUN) && (level != '0);
    assign last_lane  = (lane_idx == LANE_W'(LANES - 1));
    assign pop        = mask_valid && mask_ready && last_lane && !flush;
    assign store      = push_acc && !flush && !dup;

    rng_word_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push    (store),
        .pop     (pop),
        .clear   (flush),
        .wr_word (rnd_word),
        .head    (head),
        .level   (level)
    );

    always_comb begin
        mask = head[COEFF_SZ-1:0];
        for (int i = 1; i < LANES; i++) begin
            if (lane_idx == LANE_W'(i))
                mask = head[i*COEFF_SZ +: COEFF_SZ];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= INIT;
            lane_idx   <= '0;
            starve_cnt <= '0;
        end else if (flush) begin
            state      <= INIT;
            lane_idx   <= '0;
            starve_cnt <= '0;
        end else begin
            case (state)
                INIT: if (level >= LVL_W'(PREFILL)) state <= RUN;
                RUN:  if (level == '0 && mask_ready) starve_cnt <= sat_inc16(starve_cnt);
            endcase
            if (mask_valid && mask_ready)
                lane_idx <= last_lane ? '0 : lane_idx + LANE_W'(1);
        end
    end

`ifdef RNG_HEALTH_EN
    logic [WORD_W-1:0] last_word;
    logic              last_vld;

    // A repeated word is acknowledged but never stored, so its bits are never served.
    assign dup = last_vld && (rnd_word == last_word);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_vld   <= 1'b0;
            health_err <= 1'b0;
        end else if (flush) begin
            last_vld   <= 1'b0;
            health_err <= 1'b0;
        end else if (push_acc) begin
            if (dup)
                health_err <= 1'b1;
            else
                last_vld <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push_acc && !flush && !dup)
            last_word <= rnd_word;
    end
`else
    assign dup        = 1'b0;
    assign health_err = 1'b0;
`endif
endmodule

// File: tb/tb_rng_mask_dispenser.sv
// Bench for rng_mask_dispenser: vector table, directed corner sequences and a
// randomized run checked against a queue-based model of the dispenser.
module tb_rng_mask_dispenser;
    import kyber_rng_pkg::*;

    localparam int DEPTH   = 4;
    localparam int PREFILL = 2;

    logic                   clk = 1'b0;
    logic                   rst_n = 1'b0;
    logic [WORD_W-1:0]      rnd_word = '0;
    logic                   rnd_valid = 1'b0;
    logic                   rnd_ready;
    logic [COEFF_SZ-1:0]    mask;
    logic                   mask_valid;
    logic                   mask_ready = 1'b0;
    logic                   flush = 1'b0;
    logic [$clog2(DEPTH):0] level;
    logic [15:0]            starve_cnt;
    logic                   health_err;

    always #5 clk = ~clk;

    rng_mask_dispenser #(.DEPTH(DEPTH), .PREFILL(PREFILL)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rnd_word   (rnd_word),
        .rnd_valid  (rnd_valid),
        .rnd_ready  (rnd_ready),
        .mask       (mask),
        .mask_valid (mask_valid),
        .mask_ready (mask_ready),
        .flush      (flush),
        .level      (level),
        .starve_cnt (starve_cnt),
        .health_err (health_err)
    );

    int checks = 0;
    int errors = 0;

`ifdef RNG_HEALTH_EN
    localparam bit HEALTH = 1'b1;
`else
    localparam bit HEALTH = 1'b0;
`endif

    // Reference model state: a queue of stored words plus a lane cursor.
    logic [WORD_W-1:0] mq[$];
    int                m_lane;
    bit                m_run;
    int                m_starve;
    bit                m_herr;
    bit                m_lvld;
    logic [WORD_W-1:0] m_last;

    typedef struct {
        bit                rv;
        logic [WORD_W-1:0] w;
        bit                mr;
        bit                fl;
        bit                e_mv;
        logic [15:0]       e_mask;
        int                e_lvl;
        bit                e_rdy;
    } vec_t;

    vec_t tbl[11];

    task automatic chk(input string name, input logic [WORD_W-1:0] act, input logic [WORD_W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            if (errors <= 40)
                $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [WORD_W-1:0] mkword(input logic [15:0] b);
        logic [WORD_W-1:0] r;
        r = '0;
        for (int i = 0; i < LANES; i++)
            r[i*COEFF_SZ +: COEFF_SZ] = b + 16'(i);
        return r;
    endfunction

    task automatic model_reset();
        mq.delete();
        m_lane = 0; m_run = 0; m_starve = 0; m_herr = 0; m_lvld = 0; m_last = '0;
    endtask

    task automatic model_update(input bit rv, input logic [WORD_W-1:0] w, input bit mr, input bit fl);
        bit mv, rdy;
        mv  = m_run && (mq.size() != 0);
        rdy = (mq.size() != DEPTH);
        if (fl) begin
            model_reset();
        end else begin
            if (m_run && mq.size() == 0 && mr && m_starve < 65535)
                m_starve++;
            if (!m_run && mq.size() >= PREFILL)
                m_run = 1;
            if (mv && mr) begin
                if (m_lane == LANES - 1) begin
                    mq.delete(0);
                    m_lane = 0;
                end else begin
                    m_lane++;
                end
            end
            if (rv && rdy) begin
                if (HEALTH && m_lvld && w == m_last) begin
                    m_herr = 1;
                end else begin
                    mq.push_back(w);
                    m_last = w;
                    m_lvld = 1;
                end
            end
        end
    endtask

    task automatic model_cmp();
        logic [WORD_W-1:0] h;
        chk("rnd_ready", rnd_ready, mq.size() != DEPTH);
        chk("level", level, mq.size());
        chk("mask_valid", mask_valid, m_run && mq.size() != 0);
        if (m_run && mq.size() != 0) begin
            h = mq[0];
            chk("mask", mask, h[m_lane*COEFF_SZ +: COEFF_SZ]);
        end
        chk("starve_cnt", starve_cnt, m_starve);
        chk("health_err", health_err, m_herr);
    endtask

    // Drive one cycle of inputs, compare at the falling edge, advance past the rising edge.
    task automatic tick(input bit rv, input logic [WORD_W-1:0] w, input bit mr, input bit fl);
        rnd_valid = rv; rnd_word = w; mask_ready = mr; flush = fl;
        @(negedge clk);
        model_cmp();
        model_update(rv, w, mr, fl);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog level=%0d expected=finish", level);
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [WORD_W-1:0] prev_w, w;
        logic [WORD_W-1:0] x[5];
        int n;

        tbl[0]  = '{1'b1, mkword(16'd1), 1'b0, 1'b0, 1'b0, 16'h0, 0, 1'b1};
        tbl[1]  = '{1'b1, mkword(16'd7), 1'b0, 1'b0, 1'b0, 16'h0, 1, 1'b1};
        tbl[2]  = '{1'b0, '0,            1'b1, 1'b0, 1'b0, 16'h0, 2, 1'b1};
        tbl[3]  = '{1'b0, '0,            1'b1, 1'b0, 1'b1, 16'h1, 2, 1'b1};
        tbl[4]  = '{1'b0, '0,            1'b1, 1'b0, 1'b1, 16'h2, 2, 1'b1};
        tbl[5]  = '{1'b0, '0,            1'b1, 1'b0, 1'b1, 16'h3, 2, 1'b1};
        tbl[6]  = '{1'b0, '0,            1'b1, 1'b0, 1'b1, 16'h4, 2, 1'b1};
        tbl[7]  = '{1'b0, '0,            1'b1, 1'b0, 1'b1, 16'h5, 2, 1'b1};
        tbl[8]  = '{1'b0, '0,            1'b1, 1'b0, 1'b1, 16'h6, 2, 1'b1};
        tbl[9]  = '{1'b0, '0,            1'b0, 1'b0, 1'b1, 16'h7, 1, 1'b1};
        tbl[10] = '{1'b0, '0,            1'b0, 1'b0, 1'b1, 16'h7, 1, 1'b1};

        // Reset state
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_mask_valid", mask_valid, 1'b0);
        chk("rst_rnd_ready", rnd_ready, 1'b0);
        chk("rst_level", level, 0);
        chk("rst_starve", starve_cnt, 0);
        chk("rst_health", health_err, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Prefill latency and lane order from the vector table
        for (int i = 0; i < 11; i++) begin
            rnd_valid = tbl[i].rv; rnd_word = tbl[i].w; mask_ready = tbl[i].mr; flush = tbl[i].fl;
            @(negedge clk);
            chk($sformatf("tbl%0d_mask_valid", i), mask_valid, tbl[i].e_mv);
            if (tbl[i].e_mv)
                chk($sformatf("tbl%0d_mask", i), mask, tbl[i].e_mask);
            chk($sformatf("tbl%0d_level", i), level, tbl[i].e_lvl);
            chk($sformatf("tbl%0d_rnd_ready", i), rnd_ready, tbl[i].e_rdy);
            model_update(tbl[i].rv, tbl[i].w, tbl[i].mr, tbl[i].fl);
            @(posedge clk);
            #1;
        end

        // Full FIFO back-pressure, and a pop at lane 5 that does not free the push slot
        tick(1'b0, '0, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) x[i] = mkword(16'h100 + 16'(16 * i));
        for (int i = 0; i < 4; i++) tick(1'b1, x[i], 1'b0, 1'b0);
        tick(1'b1, x[4], 1'b0, 1'b0);
        chk("full_level", level, 4);
        chk("full_rnd_ready", rnd_ready, 1'b0);
        for (int i = 0; i < 5; i++) tick(1'b1, x[4], 1'b1, 1'b0);
        chk("lane5_mask", mask, 16'h105);
        chk("lane5_rnd_ready", rnd_ready, 1'b0);
        tick(1'b1, x[4], 1'b1, 1'b0);
        chk("after_pop_level", level, 3);
        chk("after_pop_rnd_ready", rnd_ready, 1'b1);
        chk("after_pop_mask", mask, 16'h110);
        tick(1'b1, x[4], 1'b0, 1'b0);
        chk("refill_level", level, 4);

        // Flush part way through a word; the remainder is never served
        tick(1'b0, '0, 1'b0, 1'b1);
        tick(1'b1, mkword(16'h200), 1'b0, 1'b0);
        tick(1'b1, mkword(16'h210), 1'b0, 1'b0);
        tick(1'b0, '0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) tick(1'b0, '0, 1'b1, 1'b0);
        chk("preflush_mask", mask, 16'h203);
        tick(1'b1, mkword(16'h300), 1'b1, 1'b1);
        chk("flush_level", level, 0);
        chk("flush_mask_valid", mask_valid, 1'b0);
        tick(1'b1, mkword(16'h220), 1'b0, 1'b0);
        tick(1'b1, mkword(16'h230), 1'b0, 1'b0);
        chk("init_mask_valid", mask_valid, 1'b0);
        tick(1'b0, '0, 1'b0, 1'b0);
        chk("refill_mask_valid", mask_valid, 1'b1);
        chk("refill_first_mask", mask, 16'h220);

        // Repetition test: A, A, B
        tick(1'b0, '0, 1'b0, 1'b1);
        tick(1'b1, mkword(16'h400), 1'b0, 1'b0);
        tick(1'b1, mkword(16'h400), 1'b0, 1'b0);
        chk("dup_health", health_err, HEALTH);
        tick(1'b1, mkword(16'h410), 1'b0, 1'b0);
        chk("dup_level", level, HEALTH ? 2 : 3);
        tick(1'b0, '0, 1'b0, 1'b0);
        chk("dup_health_sticky", health_err, HEALTH);
        tick(1'b0, '0, 1'b0, 1'b1);
        chk("dup_health_flushed", health_err, 1'b0);

        // Starvation counting in RUN with an empty FIFO
        tick(1'b1, mkword(16'h500), 1'b0, 1'b0);
        tick(1'b1, mkword(16'h510), 1'b0, 1'b0);
        tick(1'b0, '0, 1'b0, 1'b0);
        n = 0;
        while (level != 0 && n < 40) begin
            tick(1'b0, '0, 1'b1, 1'b0);
            n++;
        end
        chk("drain_level", level, 0);
        chk("drain_starve", starve_cnt, 0);
        repeat (10) tick(1'b0, '0, 1'b1, 1'b0);
        chk("starve_10", starve_cnt, 10);
        chk("starve_mask_valid", mask_valid, 1'b0);

        // Asynchronous reset in the middle of a word
        tick(1'b1, mkword(16'h600), 1'b0, 1'b0);
        tick(1'b1, mkword(16'h610), 1'b0, 1'b0);
        tick(1'b0, '0, 1'b1, 1'b0);
        tick(1'b0, '0, 1'b1, 1'b0);
        rnd_valid = 1'b0; mask_ready = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_mask_valid", mask_valid, 1'b0);
        chk("async_rnd_ready", rnd_ready, 1'b0);
        chk("async_level", level, 0);
        chk("async_starve", starve_cnt, 0);
        chk("async_health", health_err, 1'b0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Randomized traffic with occasional repeats and flushes
        prev_w = '0;
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 7) == 0)
                w = prev_w;
            else
                w = {$urandom, $urandom, $urandom};
            tick(($urandom_range(0, 3) != 0) ^ (i >= 750),
                 w,
                 $urandom_range(0, 3) != 0,
                 $urandom_range(0, 63) == 0);
            prev_w = w;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
